// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, FSM states and access-size decode for the load/store sequencer.
package lsu_pkg;
  typedef enum logic [2:0] {LS_W = 3'b000, LS_B = 3'b001, LS_BU = 3'b010, LS_H = 3'b011, LS_HU = 3'b100} load_size_e;
  typedef enum logic [1:0] {ST_NONE = 2'b00, ST_W = 2'b01, ST_H = 2'b10, ST_B = 2'b11} store_size_e;
  typedef enum logic [1:0] {IDLE, B1, B2, DONE} lsu_state_e;
  // Zero means the access is a no-op or an illegal encoding.
  function automatic logic [2:0] size_bytes(input logic ld, input logic [2:0] ls, input logic [1:0] mw);
    if (ld)
      return mw != ST_NONE ? 3'd0 : ls == LS_W ? 3'd4 : (ls == LS_H || ls == LS_HU) ? 3'd2 :
             (ls == LS_B || ls == LS_BU) ? 3'd1 : 3'd0;
    return mw == ST_W ? 3'd4 : mw == ST_H ? 3'd2 : mw == ST_B ? 3'd1 : 3'd0;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, write-lane rotation and read merge/extension for one access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [2:0]  ls,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic        split,
  output logic [31:0] wrot,
  output logic [31:0] rext
);
  logic [3:0] mask;
  logic [4:0] sh;
  logic [31:0] r;
  always_comb begin
    mask = size == 3'd4 ? 4'b1111 : size == 3'd2 ? 4'b0011 : 4'b0001;
    sh = {off, 3'b000};
    be_lo = mask << off;
    be_hi = mask >> (3'd4 - {1'b0, off});
    split = |be_hi;
    wrot = (wdata << sh) | (wdata >> (6'd32 - {1'b0, sh}));
    // Low beat supplies the bytes at and above off, high beat the spill-over.
    r = (lo >> sh) | (hi << (6'd32 - {1'b0, sh}));
    rext = ls == LS_B  ? {{24{r[7]}}, r[7:0]} :
           ls == LS_BU ? {24'd0, r[7:0]} :
           ls == LS_H  ? {{16{r[15]}}, r[15:0]} :
           ls == LS_HU ? {16'd0, r[15:0]} : r;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store sequencer with split beats and ack timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of splitting them.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        is_load,
  input  logic [2:0]  load_size,
  input  logic [1:0]  mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign_fault
`endif
);
  lsu_state_e state, state_n;
  logic [31:0] addr_q, wdata_q, lo_q, hi_q, cnt, rext, wrot;
  logic [2:0] ls_q, size_q, size_in;
  logic [3:0] be_lo, be_hi;
  logic ld_q, err_q, accept, ack, expire, split;
  assign size_in = size_bytes(is_load, load_size, mem_write);
  assign accept = mem_valid && size_in != 3'd0;
  assign ack = bus_ack && bus_req;
  assign expire = ACK_TIMEOUT != 0 && cnt == 32'(ACK_TIMEOUT - 1);
`ifdef LSU_MISALIGN_TRAP_EN
  logic fault_q, misalign;
  assign misalign = (size_in == 3'd2 && addr[0]) || (size_in == 3'd4 && addr[1:0] != 2'b00);
  assign misalign_fault = state == DONE && fault_q;
  always_ff @(posedge clk)
    if (reset) fault_q <= 1'b0;
    else if (state == IDLE && accept) fault_q <= misalign;
`endif
  lsu_align u_align (
    .off(addr_q[1:0]), .size(size_q), .ls(ls_q), .wdata(wdata_q), .lo(lo_q), .hi(hi_q),
    .be_lo(be_lo), .be_hi(be_hi), .split(split), .wrot(wrot), .rext(rext)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n =
`ifdef LSU_MISALIGN_TRAP_EN
        misalign ? DONE :
`endif
        B1;
      B1: state_n = ack ? (split ? B2 : DONE) : expire ? DONE : B1;
      B2: state_n = ack || expire ? DONE : B2;
      default: state_n = IDLE;
    endcase
  end
  assign bus_req = state == B1 || state == B2;
  assign bus_we = bus_req && !ld_q;
  assign bus_addr = {addr_q[31:2] + 30'(state == B2), 2'b00};
  assign bus_be = state == B1 ? be_lo : state == B2 ? be_hi : 4'b0000;
  assign bus_wdata = wrot;
  assign stall = !reset && (bus_req || (state == IDLE && accept));
  assign rdata_valid = state == DONE;
  assign bus_err = rdata_valid && err_q;
  // Captured words are cleared on accept, so trapped or bus-less accesses read back zero.
  assign rdata = rdata_valid && ld_q && !err_q ? rext : 32'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      ls_q <= '0;
      size_q <= '0;
      ld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + 32'd1;
      if (state == IDLE && accept) begin
        addr_q <= addr;
        wdata_q <= wdata;
        ld_q <= is_load;
        ls_q <= load_size;
        size_q <= size_in;
        err_q <= 1'b0;
        lo_q <= '0;
        hi_q <= '0;
      end
      if (state == B1 && ack) lo_q <= bus_rdata;
      if (state == B2 && ack) hi_q <= bus_rdata;
      if (bus_req && !ack && expire) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl with a bus responder checking each beat.
module tb_lsu_ctrl;
  logic clk = 0, reset, mem_valid, is_load, stall, rdata_valid, bus_err, bus_req, bus_we, bus_ack;
  logic [2:0] load_size;
  logic [1:0] mem_write;
  logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0] bus_be;
`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_fault;
`endif
  typedef struct {logic [31:0] a; logic [3:0] be; logic we; logic [31:0] wd; int dly; logic [31:0] rd;} beat_t;
  typedef struct {logic [31:0] rd; logic err; logic fault;} resp_t;
  beat_t beat_q[$];
  resp_t resp_q[$];
  int checks = 0, errors = 0;
  logic hold_ack = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .is_load(is_load), .load_size(load_size),
    .mem_write(mem_write), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign_fault(misalign_fault)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd, input int dly, input logic [31:0] rd);
    beat_q.push_back('{a, be, we, wd, dly, rd});
  endtask

  task automatic push_resp(input logic [31:0] rd, input logic err, input logic fault);
    resp_q.push_back('{rd, err, fault});
  endtask

  // Bus responder: checks every new beat against the expected queue and acks after its delay.
  beat_t cur;
  int dly;
  bit in_beat = 0;
  initial begin
    bus_ack = 0;
    bus_rdata = 0;
    forever begin
      @(negedge clk);
      bus_ack = 0;
      if (reset || !bus_req) in_beat = 0;
      else if (!hold_ack) begin
        if (!in_beat) begin
          if (beat_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bus_req: bus_req=1 addr=%h, required no request", bus_addr);
          end else begin
            cur = beat_q.pop_front();
            chk("beat_addr", bus_addr, cur.a);
            chk("beat_be", {28'd0, bus_be}, {28'd0, cur.be});
            chk("beat_we", {31'd0, bus_we}, {31'd0, cur.we});
            if (cur.we) chk("beat_wdata", bus_wdata, cur.wd);
            dly = cur.dly;
            in_beat = 1;
          end
        end
        if (in_beat) begin
          if (dly == 0) begin
            bus_ack = 1;
            bus_rdata = cur.rd;
            in_beat = 0;
          end else dly--;
        end
      end
    end
  end

  // Response monitor.
  resp_t r;
  always @(negedge clk) if (!reset) begin
    if (rdata_valid) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: rdata_valid=1 rdata=%h, required none", rdata);
      end else begin
        r = resp_q.pop_front();
        chk("rdata", rdata, r.rd);
        chk("bus_err", {31'd0, bus_err}, {31'd0, r.err});
`ifdef LSU_MISALIGN_TRAP_EN
        chk("misalign_fault", {31'd0, misalign_fault}, {31'd0, r.fault});
`endif
      end
    end else if (bus_err) chk("err_without_valid", {31'd0, bus_err}, 32'd0);
  end

  task automatic do_access(input logic ld, input logic [2:0] ls, input logic [1:0] mw, input logic [31:0] a, input logic [31:0] wd, input int exp_lat);
    int lat, st;
    @(negedge clk);
    mem_valid = 1; is_load = ld; load_size = ls; mem_write = mw; addr = a; wdata = wd;
    #1;
    lat = 1;
    st = int'(stall);
    while (lat < 1000) begin
      @(negedge clk);
      lat++;
      if (rdata_valid) break;
      st += int'(stall);
    end
    chk("latency", lat, exp_lat);
    chk("stall_cycles", st, exp_lat - 1);
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_req", {31'd0, bus_req}, 32'd0);
    mem_valid = 0;
  endtask

  task automatic noop(input logic ld, input logic [2:0] ls, input logic [1:0] mw);
    @(negedge clk);
    mem_valid = 1; is_load = ld; load_size = ls; mem_write = mw; addr = 32'h1000; wdata = 32'h1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("noop_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      chk("noop_req", {31'd0, bus_req}, 32'd0);
    end
    mem_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; mem_valid = 1; is_load = 1; load_size = 3'b000; mem_write = 2'b00; addr = 32'h100; wdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    chk("rst_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 0; mem_valid = 0;

    push_beat(32'h1000, 4'b1111, 0, 0, 0, 32'hDEADBEEF);
    push_resp(32'hDEADBEEF, 0, 0);
    do_access(1, 3'b000, 2'b00, 32'h1000, 0, 3);

    push_beat(32'h1000, 4'b1000, 0, 0, 0, 32'h80FFFFFF);
    push_resp(32'hFFFFFF80, 0, 0);
    do_access(1, 3'b001, 2'b00, 32'h1003, 0, 3);
    push_beat(32'h1000, 4'b1000, 0, 0, 0, 32'h80FFFFFF);
    push_resp(32'h00000080, 0, 0);
    do_access(1, 3'b010, 2'b00, 32'h1003, 0, 3);

    push_beat(32'h1000, 4'b0011, 0, 0, 0, 32'h12348001);
    push_resp(32'hFFFF8001, 0, 0);
    do_access(1, 3'b011, 2'b00, 32'h1000, 0, 3);
    push_beat(32'h1000, 4'b1100, 0, 0, 3, 32'hF00F1234);
    push_resp(32'h0000F00F, 0, 0);
    do_access(1, 3'b100, 2'b00, 32'h1002, 0, 6);

    push_beat(32'h5000, 4'b0100, 1, 32'h56781234, 1, 0);
    push_resp(0, 0, 0);
    do_access(0, 3'b000, 2'b11, 32'h5002, 32'h12345678, 4);
    push_beat(32'h6000, 4'b1111, 1, 32'hCAFEF00D, 0, 0);
    push_resp(0, 0, 0);
    do_access(0, 3'b000, 2'b01, 32'h6000, 32'hCAFEF00D, 3);

    noop(0, 3'b000, 2'b00);
    noop(1, 3'b101, 2'b00);
    noop(1, 3'b111, 2'b00);
    noop(1, 3'b000, 2'b01);

`ifndef LSU_MISALIGN_TRAP_EN
    push_beat(32'h2000, 4'b1000, 1, 32'hCD0000AB, 0, 0);
    push_beat(32'h2004, 4'b0001, 1, 32'hCD0000AB, 0, 0);
    push_resp(0, 0, 0);
    do_access(0, 3'b000, 2'b10, 32'h2003, 32'h0000ABCD, 4);

    push_beat(32'hFFFFFFFC, 4'b1100, 0, 0, 0, 32'h11223344);
    push_beat(32'h00000000, 4'b0011, 0, 0, 2, 32'h55667788);
    push_resp(32'h77881122, 0, 0);
    do_access(1, 3'b000, 2'b00, 32'hFFFFFFFE, 0, 6);

    push_beat(32'h4000, 4'b1100, 0, 0, 0, 32'hAAAAAAAA);
    push_beat(32'h4004, 4'b0011, 0, 0, 50, 32'hBBBBBBBB);
    @(negedge clk);
    mem_valid = 1; is_load = 1; load_size = 3'b000; mem_write = 2'b00; addr = 32'h4002;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_req && bus_addr == 32'h4004) break;
    end
    chk("b2_reached", bus_addr, 32'h4004);
    reset = 1;
    @(negedge clk);
    chk("b2rst_req", {31'd0, bus_req}, 32'd0);
    chk("b2rst_stall", {31'd0, stall}, 32'd0);
    chk("b2rst_valid", {31'd0, rdata_valid}, 32'd0);
    reset = 0; mem_valid = 0;
    @(negedge clk);
    chk("after_rst_req", {31'd0, bus_req}, 32'd0);
    chk("after_rst_stall", {31'd0, stall}, 32'd0);
`else
    push_resp(0, 0, 1);
    do_access(1, 3'b011, 2'b00, 32'h3001, 0, 2);
    push_resp(0, 0, 1);
    do_access(1, 3'b000, 2'b00, 32'hFFFFFFFE, 0, 2);
`endif

    hold_ack = 1;
    push_resp(0, 1, 0);
    do_access(1, 3'b000, 2'b00, 32'h7000, 0, 257);
    hold_ack = 0;

    repeat (5) @(negedge clk);
    chk("beat_q_drained", beat_q.size(), 0);
    chk("resp_q_drained", resp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
